// File: rtl/cnn_layer_1_maxpool_2x2_pkg.sv
// Layer-1 sizing defines and the max-pool package: pixel roles within a 2x2 window
// plus small sizing helpers shared by the pooling stage.
`ifndef OUTPUT_CHANNELS
`define OUTPUT_CHANNELS 8
`endif
`ifndef CHANNEL_ACCUM_BITWIDTH
`define CHANNEL_ACCUM_BITWIDTH 16
`endif
`ifndef CONV_OUT_WIDTH
`define CONV_OUT_WIDTH 24
`endif
`ifndef CONV_OUT_HEIGHT
`define CONV_OUT_HEIGHT 24
`endif
`ifndef POOL_OUT_WIDTH
`define POOL_OUT_WIDTH (`CONV_OUT_WIDTH / 2)
`endif
`ifndef POOL_OUT_HEIGHT
`define POOL_OUT_HEIGHT (`CONV_OUT_HEIGHT / 2)
`endif

package cnn_layer_1_maxpool_2x2_pkg;

    typedef enum logic [1:0] {
        PIX_SKIP,
        PIX_HOLD,
        PIX_LINE,
        PIX_POOL
    } pix_action_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Leftover column/row of an odd-sized plane only advances the counters.
    function automatic pix_action_t decode_pixel(input logic col_odd,
                                                 input logic row_odd,
                                                 input logic in_plane);
        if (!in_plane)
            return PIX_SKIP;
        if (!col_odd)
            return PIX_HOLD;
        if (!row_odd)
            return PIX_LINE;
        return PIX_POOL;
    endfunction

endpackage

// File: rtl/maxpool_signed_max.sv
// Two's-complement maximum of two DW-bit values; on a tie either operand is the answer.
module maxpool_signed_max #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    assign y = ($signed(a) > $signed(b)) ? a : b;

endmodule

// File: rtl/cnn_layer_1_maxpool_2x2.sv
// Layer-1 2x2 / stride-2 max-pool: horizontal max against h_reg, vertical max against
// a half-width line buffer holding the even row's horizontal maxima.
module cnn_layer_1_maxpool_2x2
    import cnn_layer_1_maxpool_2x2_pkg::*;
#(
    parameter int CH   = `OUTPUT_CHANNELS,
    parameter int DW   = `CHANNEL_ACCUM_BITWIDTH,
    parameter int IN_W = `CONV_OUT_WIDTH,
    parameter int IN_H = `CONV_OUT_HEIGHT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_clr,
    input  logic             in_valid,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    output logic [CH*DW-1:0] out_data,
    output logic             out_last
);

    localparam int OUT_W = IN_W / 2;
    localparam int OUT_H = IN_H / 2;
    localparam int CW    = cnt_width(IN_W);
    localparam int RW    = cnt_width(IN_H);
    localparam int LW    = cnt_width(OUT_W);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [LW-1:0]    cidx;
    logic [CH*DW-1:0] h_reg;
    logic [CH*DW-1:0] hmax;
    logic [CH*DW-1:0] vmax;
    logic [CH*DW-1:0] lbuf_rd;
    logic [CH*DW-1:0] lbuf [OUT_W];
    logic             accept;
    logic             col_end;
    logic             row_end;
    logic             last_win;
    logic             in_plane;
    pix_action_t      action;

    assign accept   = in_valid && !frame_clr;
    assign col_end  = (col == CW'(IN_W - 1));
    assign row_end  = (row == RW'(IN_H - 1));
    assign in_plane = (int'(col) < 2 * OUT_W) && (int'(row) < 2 * OUT_H);
    assign last_win = (int'(row) == 2 * OUT_H - 1) && (int'(col) == 2 * OUT_W - 1);
    assign cidx     = LW'(col >> 1);
    assign action   = decode_pixel(col[0], row[0], in_plane);
    assign lbuf_rd  = lbuf[cidx];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        maxpool_signed_max #(.DW(DW)) u_hmax (
            .a (h_reg[c*DW +: DW]),
            .b (in_data[c*DW +: DW]),
            .y (hmax[c*DW +: DW])
        );
        maxpool_signed_max #(.DW(DW)) u_vmax (
            .a (lbuf_rd[c*DW +: DW]),
            .b (hmax[c*DW +: DW]),
            .y (vmax[c*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            h_reg     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (frame_clr) begin
            col       <= '0;
            row       <= '0;
            h_reg     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                case (action)
                    PIX_HOLD: h_reg <= in_data;
                    PIX_POOL: begin
                        out_data  <= vmax;
                        out_valid <= 1'b1;
                        out_last  <= last_win;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Line buffer needs no reset: every entry is written on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (reset_n && accept && action == PIX_LINE)
            lbuf[cidx] <= hmax;
    end

endmodule

// File: tb/tb_cnn_layer_1_maxpool_2x2.sv
// Directed bench for the layer-1 max-pool: 4x4, 5x5 and 24x24 instances share one stimulus bus,
// with a per-instance select gating in_valid.
`timescale 1ns/1ps
module tb_cnn_layer_1_maxpool_2x2;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_clr = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    int                sel = 0;

    logic              v4, v5, v24;
    logic              ov4, ov5, ov24;
    logic              ol4, ol5, ol24;
    logic [DATA_W-1:0] od4, od5, od24;

    logic [DATA_W-1:0] q4[$];
    logic [DATA_W-1:0] q5[$];
    logic [DATA_W-1:0] q24[$];
    int                last4 = 0, last5 = 0, last24 = 0;
    int                checkCount = 0, passCount = 0;

    logic              expPend, expLast;
    logic [DATA_W-1:0] holdData;
    logic [7:0]        signedVec [16];
    logic [7:0]        signedExp [4];
    int                v5val;

    assign v4  = in_valid && (sel == 0);
    assign v5  = in_valid && (sel == 1);
    assign v24 = in_valid && (sel == 2);

    always #5 clk = ~clk;

    cnn_layer_1_maxpool_2x2 #(.CH(2), .DW(8), .IN_W(4), .IN_H(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .frame_clr(frame_clr), .in_valid(v4),
        .in_data(in_data), .out_valid(ov4), .out_data(od4), .out_last(ol4));

    cnn_layer_1_maxpool_2x2 #(.CH(2), .DW(8), .IN_W(5), .IN_H(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .frame_clr(frame_clr), .in_valid(v5),
        .in_data(in_data), .out_valid(ov5), .out_data(od5), .out_last(ol5));

    cnn_layer_1_maxpool_2x2 #(.CH(2), .DW(8), .IN_W(24), .IN_H(24)) dut24 (
        .clk(clk), .reset_n(reset_n), .frame_clr(frame_clr), .in_valid(v24),
        .in_data(in_data), .out_valid(ov24), .out_data(od24), .out_last(ol24));

    always @(negedge clk) begin
        if (ov4) begin q4.push_back(od4); last4 += int'(ol4); end
        if (ov5) begin q5.push_back(od5); last5 += int'(ol5); end
        if (ov24) begin q24.push_back(od24); last24 += int'(ol24); end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int which, input logic valid, input logic [DATA_W-1:0] data, input logic clr);
        @(negedge clk);
        sel       = which;
        in_valid  = valid;
        in_data   = data;
        frame_clr = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [7:0] pix24(input int seed, input int r, input int c, input int ch);
        int v;
        v = r * 37 + c * 101 + ch * 59 + seed * 71 + ((r * c) % 17) * 29;
        return v[7:0];
    endfunction

    function automatic logic [DATA_W-1:0] pack24(input int seed, input int r, input int c);
        return {pix24(seed, r, c, 1), pix24(seed, r, c, 0)};
    endfunction

    function automatic logic [DATA_W-1:0] exp24(input int seed, input int wr, input int wc);
        logic [DATA_W-1:0] res;
        logic signed [7:0] m, p;
        res = '0;
        for (int ch = 0; ch < 2; ch++) begin
            m = pix24(seed, 2 * wr, 2 * wc, ch);
            for (int k = 1; k < 4; k++) begin
                p = pix24(seed, 2 * wr + k / 2, 2 * wc + k % 2, ch);
                if (p > m) m = p;
            end
            res[ch*8 +: 8] = m;
        end
        return res;
    endfunction

    task automatic sendBeats24(input int seed, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                idle(int'($urandom_range(1, 3)));
            applyStimulus(2, 1'b1, pack24(seed, i / 24, i % 24), 1'b0);
        end
    endtask

    task automatic checkFrame24(input string tag, input int seed, input int base);
        int bad;
        bad = 0;
        for (int i = 0; i < 144; i++)
            if (base + i >= q24.size() || q24[base + i] !== exp24(seed, i / 12, i % 12))
                bad++;
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    task automatic clearQueues();
        q4.delete(); q5.delete(); q24.delete();
        last4 = 0; last5 = 0; last24 = 0;
    endtask

    initial begin
        signedVec = '{8'hfb, 8'hfe, 8'h00, 8'hff,
                      8'hf7, 8'hf9, 8'hff, 8'hff,
                      8'h03, 8'h03, 8'h80, 8'h7f,
                      8'h03, 8'h03, 8'h80, 8'h80};
        signedExp = '{8'hfe, 8'h00, 8'h03, 8'h7f};

        idle(3);
        checkOutput("rst_valid4", 32'(ov4), 32'd0);
        checkOutput("rst_data4", 32'(od4), 32'd0);
        checkOutput("rst_last24", 32'(ol24), 32'd0);
        checkOutput("rst_data24", 32'(od24), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // 4x4 ramp, channel c = 16*row + col + c; every cycle checks the previous beat's effect
        expPend  = 1'b0;
        expLast  = 1'b0;
        holdData = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(0, 1'b1, {8'(16 * r + c + 1), 8'(16 * r + c)}, 1'b0);
                checkOutput("ramp_valid", 32'(ov4), 32'(expPend));
                checkOutput("ramp_data", 32'(od4), 32'(holdData));
                checkOutput("ramp_last", 32'(ol4), 32'(expLast));
                expPend = (r % 2 == 1) && (c % 2 == 1);
                expLast = (r == 3) && (c == 3);
                if (expPend) holdData = {8'(16 * r + c + 1), 8'(16 * r + c)};
            end
        end
        applyStimulus(0, 1'b0, '0, 1'b0);
        checkOutput("ramp_valid_end", 32'(ov4), 32'd1);
        checkOutput("ramp_data_end", 32'(od4), 32'h3433);
        checkOutput("ramp_last_end", 32'(ol4), 32'd1);
        idle(1);
        checkOutput("ramp_hold_after", 32'(od4), 32'h3433);
        checkOutput("ramp_count", 32'(q4.size()), 32'd4);
        checkOutput("ramp_last_count", 32'(last4), 32'd1);

        // signed windows, including ties and the extreme codes
        idle(2);
        clearQueues();
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1'b1, {signedVec[i], signedVec[i]}, 1'b0);
        idle(3);
        checkOutput("signed_count", 32'(q4.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("signed_data", (i < q4.size()) ? 32'(q4[i]) : 32'hdead,
                        32'({signedExp[i], signedExp[i]}));

        // 5x5 plane, two frames: row 4 and col 4 carry 127 and must never reach the output
        clearQueues();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    v5val = (r == 4 || c == 4) ? 127 : 10 * r + c + f;
                    applyStimulus(1, 1'b1, {8'(v5val), 8'(v5val)}, 1'b0);
                end
        idle(3);
        checkOutput("odd_count", 32'(q5.size()), 32'd8);
        checkOutput("odd_last_count", 32'(last5), 32'd2);
        checkOutput("odd_w0_f0", (q5.size() > 0) ? 32'(q5[0]) : 32'hdead, 32'h0b0b);
        checkOutput("odd_w3_f0", (q5.size() > 3) ? 32'(q5[3]) : 32'hdead, 32'h2121);
        checkOutput("odd_w0_f1", (q5.size() > 4) ? 32'(q5[4]) : 32'hdead, 32'h0c0c);
        checkOutput("odd_w3_f1", (q5.size() > 7) ? 32'(q5[7]) : 32'hdead, 32'h2222);

        // 24x24 frame with random in_valid gaps
        clearQueues();
        sendBeats24(1, 576, 1'b1);
        idle(4);
        checkOutput("gap_count", 32'(q24.size()), 32'd144);
        checkOutput("gap_last_count", 32'(last24), 32'd1);
        checkFrame24("gap_data", 1, 0);

        // two frames back to back
        clearQueues();
        sendBeats24(2, 576, 1'b0);
        sendBeats24(5, 576, 1'b0);
        idle(4);
        checkOutput("b2b_count", 32'(q24.size()), 32'd288);
        checkOutput("b2b_last_count", 32'(last24), 32'd2);
        checkFrame24("b2b_frame0", 2, 0);
        checkFrame24("b2b_frame1", 5, 144);

        // async reset mid-frame
        sendBeats24(3, 30, 1'b0);
        idle(1);
        reset_n = 1'b0;
        idle(2);
        checkOutput("midrst_valid", 32'(ov24), 32'd0);
        checkOutput("midrst_data", 32'(od24), 32'd0);
        reset_n = 1'b1;
        idle(1);
        clearQueues();
        sendBeats24(4, 576, 1'b0);
        idle(4);
        checkOutput("midrst_count", 32'(q24.size()), 32'd144);
        checkOutput("midrst_first", (q24.size() > 0) ? 32'(q24[0]) : 32'hdead, 32'(exp24(4, 0, 0)));
        checkFrame24("midrst_frame", 4, 0);

        // one-cycle frame_clr mid-frame; the pulse from the last window still appears that cycle
        sendBeats24(6, 30, 1'b0);
        applyStimulus(2, 1'b0, '0, 1'b1);
        checkOutput("clr_pulse", 32'(ov24), 32'd1);
        applyStimulus(2, 1'b0, '0, 1'b0);
        checkOutput("clr_valid", 32'(ov24), 32'd0);
        checkOutput("clr_data", 32'(od24), 32'd0);
        idle(1);
        clearQueues();
        sendBeats24(7, 576, 1'b0);
        idle(4);
        checkOutput("clr_count", 32'(q24.size()), 32'd144);
        checkOutput("clr_first", (q24.size() > 0) ? 32'(q24[0]) : 32'hdead, 32'(exp24(7, 0, 0)));
        checkFrame24("clr_frame", 7, 0);

        // frame_clr together with in_valid: that beat must be dropped
        sendBeats24(8, 30, 1'b0);
        applyStimulus(2, 1'b1, 16'h7f7f, 1'b1);
        idle(2);
        clearQueues();
        sendBeats24(9, 576, 1'b0);
        idle(4);
        checkOutput("clrv_count", 32'(q24.size()), 32'd144);
        checkOutput("clrv_last_count", 32'(last24), 32'd1);
        checkFrame24("clrv_frame", 9, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
